// File: rtl/wb_shared_bus.sv
// wb_shared_bus: shared Wishbone path, N masters to M slaves.
// Round-robin grant, 4-bit region decode, unmapped and watchdog errors.
module wb_shared_bus #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [4*NUM_SLAVES-1:0] SLV_ID = {4'h2, 4'h1, 4'h0},
  parameter int TIMEOUT = 255,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
  output logic [NUM_MASTERS*DATA_W-1:0] m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_SLAVES-1:0]         s_cyc_o,
  output logic [NUM_SLAVES-1:0]         s_stb_o,
  output logic [ADDR_W-1:0]             s_adr_o,
  output logic [DATA_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]              s_sel_o,
  output logic                          s_we_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]         s_ack_i,
  input  logic [NUM_SLAVES-1:0]         s_err_i,
  output logic                          owner_vld_o,
  output logic [2:0]                    owner_o
);

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    ERR
  } state_t;

  state_t state;
  logic [2:0] own;
  logic [2:0] last;
  logic [2:0] gnt;
  logic found;
  logic [15:0] cnt;

  logic o_cyc;
  logic o_stb;
  logic o_we;
  logic [ADDR_W-1:0] o_adr;
  logic [DATA_W-1:0] o_dat;
  logic [SEL_W-1:0] o_sel;

  logic hit;
  logic [3:0] hk;
  logic k_ack;
  logic k_err;
  logic [DATA_W-1:0] k_dat;

  logic owned;
  logic term;
  logic expire;

  // Select the owning master's request signals.
  always_comb begin
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_we = 1'b0;
    o_adr = '0;
    o_dat = '0;
    o_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (own == 3'(i)) begin
        o_cyc = m_cyc_i[i];
        o_stb = m_stb_i[i];
        o_we = m_we_i[i];
        o_adr = m_adr_i[i*ADDR_W +: ADDR_W];
        o_dat = m_dat_i[i*DATA_W +: DATA_W];
        o_sel = m_sel_i[i*SEL_W +: SEL_W];
      end
    end
  end

  // First requester after the last grant, wrapping around.
  always_comb begin
    gnt = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && m_cyc_i[j] &&
            j == (int'(last) + i) % NUM_MASTERS) begin
          found = 1'b1;
          gnt = 3'(j);
        end
      end
    end
  end

  // Region decode; the lowest matching slave index wins.
  always_comb begin
    hit = 1'b0;
    hk = '0;
    k_ack = 1'b0;
    k_err = 1'b0;
    k_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (!hit &&
          o_adr[ADDR_W-1 -: 4] == SLV_ID[4*k +: 4]) begin
        hit = 1'b1;
        hk = 4'(k);
        k_ack = s_ack_i[k];
        k_err = s_err_i[k];
        k_dat = s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign owned = (state == OWNED);
  assign term = hit & (k_ack | k_err);
  assign expire = owned & o_cyc & o_stb & hit & ~term &
                  (cnt == 16'(TIMEOUT));

  // Route strobes to the decoded slave and terminations back.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (owned && hit && !expire && hk == 4'(k)) begin
        s_cyc_o[k] = o_cyc;
        s_stb_o[k] = o_cyc & o_stb;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (own == 3'(i)) begin
        m_ack_o[i] = owned & hit & k_ack;
        m_err_o[i] = (state == ERR) | expire |
                     (owned & hit & k_err);
      end
      if (owned && hit) begin
        m_dat_o[i*DATA_W +: DATA_W] = k_dat;
      end
    end
  end

  assign s_adr_o = (state != IDLE) ? o_adr : '0;
  assign s_dat_o = (state != IDLE) ? o_dat : '0;
  assign s_sel_o = (state != IDLE) ? o_sel : '0;
  assign s_we_o = (state != IDLE) & o_we;
  assign owner_vld_o = (state != IDLE);
  assign owner_o = own;

  // Ownership FSM and bus watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last <= 3'(NUM_MASTERS - 1);
      own <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (|m_cyc_i) begin
            own <= gnt;
            last <= gnt;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!o_cyc) begin
            state <= IDLE;
            cnt <= '0;
          end else if (o_stb && !hit) begin
            state <= ERR;
            cnt <= '0;
          end else if (o_stb && !term && !expire) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt <= '0;
          end
        end
        ERR: begin
          state <= OWNED;
          cnt <= '0;
        end
        default: begin
          state <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
